// File: rtl/burst_mem_ddr_bridge_if.sv
// Bus bundle between the burst memory arbiter port (in_*) and the Avalon-MM DDR master (ddr_*).
// The bridge uses the slave modport; the arbiter/DDR environment uses the master modport.
interface burst_mem_ddr_bridge_if #(
   parameter int ADDR_WIDTH         = 32,
   parameter int DATA_WIDTH         = 64,
   parameter int BURST_LENGTH_WIDTH = 8
);
   logic                          in_rd;
   logic                          in_wr;
   logic [ADDR_WIDTH-1:0]         in_addr;
   logic [DATA_WIDTH/8-1:0]       in_mask;
   logic [DATA_WIDTH-1:0]         in_din;
   logic [BURST_LENGTH_WIDTH-1:0] in_burstLength;
   logic [DATA_WIDTH-1:0]         in_dout;
   logic                          in_wait_n;
   logic                          in_valid;
   logic                          in_burstDone;

   logic                          ddr_rd;
   logic                          ddr_wr;
   logic [ADDR_WIDTH-1:0]         ddr_addr;
   logic [DATA_WIDTH/8-1:0]       ddr_byteenable;
   logic [DATA_WIDTH-1:0]         ddr_writedata;
   logic [BURST_LENGTH_WIDTH-1:0] ddr_burstcount;
   logic [DATA_WIDTH-1:0]         ddr_readdata;
   logic                          ddr_waitrequest;
   logic                          ddr_readdatavalid;

   modport slave (
      input  in_rd, in_wr, in_addr, in_mask, in_din, in_burstLength,
      input  ddr_readdata, ddr_waitrequest, ddr_readdatavalid,
      output in_dout, in_wait_n, in_valid, in_burstDone,
      output ddr_rd, ddr_wr, ddr_addr, ddr_byteenable, ddr_writedata, ddr_burstcount
   );

   modport master (
      output in_rd, in_wr, in_addr, in_mask, in_din, in_burstLength,
      output ddr_readdata, ddr_waitrequest, ddr_readdatavalid,
      input  in_dout, in_wait_n, in_valid, in_burstDone,
      input  ddr_rd, ddr_wr, ddr_addr, ddr_byteenable, ddr_writedata, ddr_burstcount
   );
endinterface

// File: rtl/burst_mem_ddr_bridge.sv
// BurstMem-to-Avalon-MM burst bridge with beat counting and burstDone generation, one burst in flight.
// Optional sticky protocol error flag on port err when BURST_MEM_DDR_BRIDGE_ERR_EN is defined.
module burst_mem_ddr_bridge #(
   parameter int ADDR_WIDTH         = 32,
   parameter int DATA_WIDTH         = 64,
   parameter int BURST_LENGTH_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   burst_mem_ddr_bridge_if.slave  bus
`ifdef BURST_MEM_DDR_BRIDGE_ERR_EN
   ,
   output logic                   err
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_READ  = 2'd2;

   localparam logic [BURST_LENGTH_WIDTH-1:0] LEN_ONE = BURST_LENGTH_WIDTH'(1);

   logic [1:0]                    state_q, state_d;
   logic [BURST_LENGTH_WIDTH-1:0] cnt_q, cnt_d;
   logic [BURST_LENGTH_WIDTH-1:0] len_q, len_d;
   logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
   logic [BURST_LENGTH_WIDTH-1:0] eff_len;
   logic                          wr_beat;
   logic                          rd_acc;
   logic                          done;

   assign eff_len = (bus.in_burstLength == '0) ? LEN_ONE : bus.in_burstLength;

   // Every output is forced to zero while reset is low, so all drives sit under the reset guard.
   always_comb begin
      state_d             = state_q;
      cnt_d               = cnt_q;
      len_d               = len_q;
      addr_d              = addr_q;
      wr_beat             = 1'b0;
      rd_acc              = 1'b0;
      done                = 1'b0;
      bus.in_dout         = '0;
      bus.in_wait_n       = 1'b0;
      bus.in_valid        = 1'b0;
      bus.in_burstDone    = 1'b0;
      bus.ddr_rd          = 1'b0;
      bus.ddr_wr          = 1'b0;
      bus.ddr_addr        = '0;
      bus.ddr_byteenable  = '0;
      bus.ddr_writedata   = '0;
      bus.ddr_burstcount  = '0;
      if (reset) begin
         bus.in_dout = bus.ddr_readdata;
         case (state_q)
            ST_IDLE: begin
               bus.ddr_wr         = bus.in_wr;
               bus.ddr_rd         = bus.in_rd & ~bus.in_wr;
               bus.ddr_addr       = bus.in_addr;
               bus.ddr_burstcount = eff_len;
               bus.ddr_byteenable = bus.in_mask;
               bus.ddr_writedata  = bus.in_din;
               bus.in_wait_n      = ~bus.ddr_waitrequest;
               wr_beat            = bus.in_wr & ~bus.ddr_waitrequest;
               rd_acc             = bus.in_rd & ~bus.in_wr & ~bus.ddr_waitrequest;
               if (wr_beat || rd_acc) begin
                  addr_d = bus.in_addr;
                  len_d  = eff_len;
               end
               if (wr_beat) begin
                  if (eff_len == LEN_ONE) begin
                     done = 1'b1;
                  end else begin
                     cnt_d   = LEN_ONE;
                     state_d = ST_WRITE;
                  end
               end else if (rd_acc) begin
                  cnt_d   = '0;
                  state_d = ST_READ;
               end
            end
            ST_WRITE: begin
               bus.ddr_wr         = bus.in_wr;
               bus.ddr_addr       = addr_q;
               bus.ddr_burstcount = len_q;
               bus.ddr_byteenable = bus.in_mask;
               bus.ddr_writedata  = bus.in_din;
               bus.in_wait_n      = ~bus.ddr_waitrequest;
               wr_beat            = bus.in_wr & ~bus.ddr_waitrequest;
               if (wr_beat) begin
                  cnt_d = cnt_q + LEN_ONE;
                  if (cnt_q == len_q - LEN_ONE) begin
                     done    = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_READ: begin
               bus.in_valid = bus.ddr_readdatavalid;
               if (bus.ddr_readdatavalid) begin
                  cnt_d = cnt_q + LEN_ONE;
                  if (cnt_q == len_q - LEN_ONE) begin
                     done    = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
         bus.in_burstDone = done;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
      end
   end

`ifdef BURST_MEM_DDR_BRIDGE_ERR_EN
   logic err_q, err_d;

   // Sticky: stray read data, a read/write collision, or a zero length at command acceptance.
   always_comb begin
      err_d = err_q;
      if ((state_q != ST_READ) && bus.ddr_readdatavalid)
         err_d = 1'b1;
      if ((state_q == ST_IDLE) && bus.in_rd && bus.in_wr)
         err_d = 1'b1;
      if ((state_q == ST_IDLE) && (wr_beat || rd_acc) && (bus.in_burstLength == '0))
         err_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q & reset;
`endif

endmodule

// File: tb/tb_burst_mem_ddr_bridge.sv
// Self-checking bench for burst_mem_ddr_bridge: command table plus read/reset/back-to-back sequences.
// Read data is scoreboarded: pushed when readdatavalid is driven, popped when in_valid is seen.
module tb_burst_mem_ddr_bridge;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int BW = 8;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   burst_mem_ddr_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH_WIDTH(BW)) bus ();

`ifdef BURST_MEM_DDR_BRIDGE_ERR_EN
   logic err;
`endif

   burst_mem_ddr_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH_WIDTH(BW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
`ifdef BURST_MEM_DDR_BRIDGE_ERR_EN
      ,
      .err   (err)
`endif
   );

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] sb_q[$];

   typedef struct {
      logic          rst, rd, wr;
      logic [AW-1:0] addr;
      logic [7:0]    mask;
      logic [DW-1:0] din;
      logic [BW-1:0] blen;
      logic          wreq;
      logic          erd, ewr;
      logic [AW-1:0] eaddr;
      logic [BW-1:0] ebc;
      logic          ewn, edone;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [7:0] mask, input logic [DW-1:0] din, input logic [BW-1:0] blen,
                        input logic wreq, input logic [DW-1:0] rdata, input logic rdv);
      reset                 = rst;
      bus.in_rd             = rd;
      bus.in_wr             = wr;
      bus.in_addr           = addr;
      bus.in_mask           = mask;
      bus.in_din            = din;
      bus.in_burstLength    = blen;
      bus.ddr_waitrequest   = wreq;
      bus.ddr_readdata      = rdata;
      bus.ddr_readdatavalid = rdv;
   endtask

   // Checks the combinational outputs mid-cycle, then advances to just after the next rising edge.
   task automatic expect_cyc(input string tag, input logic erd, input logic ewr, input logic [AW-1:0] eaddr,
                             input logic [BW-1:0] ebc, input logic ewn, input logic evalid, input logic edone);
      logic [DW-1:0] exp_d;
      #2;
      chk({tag, ".ddr_rd"}, bus.ddr_rd, erd);
      chk({tag, ".ddr_wr"}, bus.ddr_wr, ewr);
      chk({tag, ".wait_n"}, bus.in_wait_n, ewn);
      chk({tag, ".valid"}, bus.in_valid, evalid);
      chk({tag, ".done"}, bus.in_burstDone, edone);
      if (erd || ewr) begin
         chk({tag, ".addr"}, bus.ddr_addr, eaddr);
         chk({tag, ".burstcount"}, bus.ddr_burstcount, ebc);
      end
      if (ewr) begin
         chk({tag, ".writedata"}, bus.ddr_writedata, bus.in_din);
         chk({tag, ".byteenable"}, bus.ddr_byteenable, bus.in_mask);
      end
      if (!reset) begin
         chk({tag, ".rst_dout"}, bus.in_dout, 0);
         chk({tag, ".rst_addr"}, bus.ddr_addr, 0);
         chk({tag, ".rst_wdata"}, bus.ddr_writedata, 0);
         chk({tag, ".rst_be"}, bus.ddr_byteenable, 0);
         chk({tag, ".rst_bc"}, bus.ddr_burstcount, 0);
      end
      if (bus.in_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.sb actual=unexpected_beat required=no_beat", tag);
         end else begin
            exp_d = sb_q.pop_front();
            chk({tag, ".dout"}, bus.in_dout, exp_d);
         end
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [DW-1:0] rdata;

      //            rst rd wr addr        mask   din       blen  wq  erd ewr eaddr      ebc   ewn edone
      vecs[0]  = '{1'b0,1'b0,1'b1,32'h100,8'hFF,64'h11,   8'd1, 1'b0, 1'b0,1'b0,32'h0,  8'd0, 1'b0,1'b0};
      vecs[1]  = '{1'b1,1'b0,1'b0,32'h0,  8'h00,64'h0,    8'd0, 1'b0, 1'b0,1'b0,32'h0,  8'd0, 1'b1,1'b0};
      vecs[2]  = '{1'b1,1'b0,1'b1,32'h100,8'hFF,64'hA5A5, 8'd1, 1'b0, 1'b0,1'b1,32'h100,8'd1, 1'b1,1'b1};
      vecs[3]  = '{1'b1,1'b0,1'b1,32'h200,8'h0F,64'h1,    8'd4, 1'b0, 1'b0,1'b1,32'h200,8'd4, 1'b1,1'b0};
      vecs[4]  = '{1'b1,1'b0,1'b1,32'h999,8'hF0,64'h2,    8'd9, 1'b1, 1'b0,1'b1,32'h200,8'd4, 1'b0,1'b0};
      vecs[5]  = '{1'b1,1'b0,1'b1,32'h999,8'hF0,64'h2,    8'd9, 1'b1, 1'b0,1'b1,32'h200,8'd4, 1'b0,1'b0};
      vecs[6]  = '{1'b1,1'b0,1'b1,32'h999,8'hF0,64'h2,    8'd9, 1'b0, 1'b0,1'b1,32'h200,8'd4, 1'b1,1'b0};
      vecs[7]  = '{1'b1,1'b1,1'b1,32'h998,8'h33,64'h3,    8'd9, 1'b0, 1'b0,1'b1,32'h200,8'd4, 1'b1,1'b0};
      vecs[8]  = '{1'b1,1'b0,1'b1,32'h997,8'hCC,64'h4,    8'd9, 1'b0, 1'b0,1'b1,32'h200,8'd4, 1'b1,1'b1};
      vecs[9]  = '{1'b1,1'b1,1'b1,32'h400,8'hFF,64'h5,    8'd2, 1'b0, 1'b0,1'b1,32'h400,8'd2, 1'b1,1'b0};
      vecs[10] = '{1'b1,1'b0,1'b1,32'h500,8'hFF,64'h6,    8'd2, 1'b0, 1'b0,1'b1,32'h400,8'd2, 1'b1,1'b1};
      vecs[11] = '{1'b1,1'b0,1'b0,32'h0,  8'h00,64'h0,    8'd1, 1'b0, 1'b0,1'b0,32'h0,  8'd0, 1'b1,1'b0};

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].mask, vecs[i].din,
               vecs[i].blen, vecs[i].wreq, 64'h0, 1'b0);
         expect_cyc($sformatf("vec%0d", i), vecs[i].erd, vecs[i].ewr, vecs[i].eaddr, vecs[i].ebc,
                    vecs[i].ewn, 1'b0, vecs[i].edone);
      end

      // Read burst of 16: data starts 5 cycles after accept, one-cycle gap after beat 8.
      drive(1, 1, 0, 32'h300, 8'h00, 64'h0, 8'd16, 0, 64'h0, 0);
      expect_cyc("rd16.acc", 1, 0, 32'h300, 8'd16, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 0, 32'h300, 8'h00, 64'h0, 8'd16, 0, 64'hDEAD, 0);
         expect_cyc("rd16.lat", 0, 0, 32'h0, 8'd0, 0, 0, 0);
      end
      for (int b = 0; b < 16; b++) begin
         if (b == 8) begin
            drive(1, 0, 0, 32'h0, 8'h00, 64'h0, 8'd1, 0, 64'hBEEF, 0);
            expect_cyc("rd16.gap", 0, 0, 32'h0, 8'd0, 0, 0, 0);
         end
         rdata = {$urandom, $urandom};
         sb_q.push_back(rdata);
         drive(1, 0, 0, 32'h0, 8'h00, 64'h0, 8'd1, 0, rdata, 1);
         expect_cyc($sformatf("rd16.beat%0d", b), 0, 0, 32'h0, 8'd0, 0, 1, (b == 15));
      end
      drive(1, 0, 0, 32'h0, 8'h00, 64'h0, 8'd1, 0, 64'h0, 0);
      expect_cyc("rd16.idle", 0, 0, 32'h0, 8'd0, 1, 0, 0);

      // Back-to-back: single-beat read, then a 2-beat write the cycle after burstDone.
      drive(1, 1, 0, 32'h600, 8'h00, 64'h0, 8'd1, 0, 64'h0, 0);
      expect_cyc("b2b.rd", 1, 0, 32'h600, 8'd1, 1, 0, 0);
      sb_q.push_back(64'h0123_4567_89AB_CDEF);
      drive(1, 0, 0, 32'h0, 8'h00, 64'h0, 8'd1, 0, 64'h0123_4567_89AB_CDEF, 1);
      expect_cyc("b2b.rdbeat", 0, 0, 32'h0, 8'd0, 0, 1, 1);
      drive(1, 0, 1, 32'h700, 8'h5A, 64'h77, 8'd2, 0, 64'h0, 0);
      expect_cyc("b2b.wr1", 0, 1, 32'h700, 8'd2, 1, 0, 0);
      drive(1, 0, 1, 32'h0, 8'hA5, 64'h78, 8'd2, 0, 64'h0, 0);
      expect_cyc("b2b.wr2", 0, 1, 32'h700, 8'd2, 1, 0, 1);

      // Reset in the middle of an 8-beat read; late beats must be dropped.
      drive(1, 1, 0, 32'h800, 8'h00, 64'h0, 8'd8, 0, 64'h0, 0);
      expect_cyc("rst.acc", 1, 0, 32'h800, 8'd8, 1, 0, 0);
      for (int b = 0; b < 3; b++) begin
         rdata = {$urandom, $urandom};
         sb_q.push_back(rdata);
         drive(1, 0, 0, 32'h0, 8'h00, 64'h0, 8'd1, 0, rdata, 1);
         expect_cyc($sformatf("rst.beat%0d", b), 0, 0, 32'h0, 8'd0, 0, 1, 0);
      end
      drive(0, 1, 1, 32'h123, 8'hFF, 64'h99, 8'd8, 0, 64'hCAFE, 1);
      expect_cyc("rst.asserted", 0, 0, 32'h0, 8'd0, 0, 0, 0);
      for (int b = 0; b < 4; b++) begin
         drive(1, 0, 0, 32'h0, 8'h00, 64'h0, 8'd1, 0, 64'hF00D + b, 1);
         expect_cyc($sformatf("rst.drop%0d", b), 0, 0, 32'h0, 8'd0, 1, 0, 0);
      end
      drive(1, 1, 0, 32'h900, 8'h00, 64'h0, 8'd1, 0, 64'h0, 0);
      expect_cyc("rst.fresh", 1, 0, 32'h900, 8'd1, 1, 0, 0);
      sb_q.push_back(64'h5555_AAAA_0000_FFFF);
      drive(1, 0, 0, 32'h0, 8'h00, 64'h0, 8'd1, 0, 64'h5555_AAAA_0000_FFFF, 1);
      expect_cyc("rst.freshbeat", 0, 0, 32'h0, 8'd0, 0, 1, 1);

      // Zero burst length read behaves as a single beat (and raises err when present).
      drive(0, 0, 0, 32'h0, 8'h00, 64'h0, 8'd1, 0, 64'h0, 0);
      expect_cyc("len0.rst", 0, 0, 32'h0, 8'd0, 0, 0, 0);
`ifdef BURST_MEM_DDR_BRIDGE_ERR_EN
      chk("err.after_rst", err, 0);
`endif
      drive(1, 1, 0, 32'hA00, 8'h00, 64'h0, 8'd0, 0, 64'h0, 0);
      expect_cyc("len0.acc", 1, 0, 32'hA00, 8'd1, 1, 0, 0);
`ifdef BURST_MEM_DDR_BRIDGE_ERR_EN
      chk("err.set", err, 1);
`endif
      sb_q.push_back(64'h0000_1111_2222_3333);
      drive(1, 0, 0, 32'h0, 8'h00, 64'h0, 8'd1, 0, 64'h0000_1111_2222_3333, 1);
      expect_cyc("len0.beat", 0, 0, 32'h0, 8'd0, 0, 1, 1);
      drive(1, 0, 0, 32'h0, 8'h00, 64'h0, 8'd1, 0, 64'h0, 0);
      expect_cyc("len0.idle", 0, 0, 32'h0, 8'd0, 1, 0, 0);
`ifdef BURST_MEM_DDR_BRIDGE_ERR_EN
      chk("err.sticky", err, 1);
      drive(0, 0, 0, 32'h0, 8'h00, 64'h0, 8'd1, 0, 64'h0, 0);
      expect_cyc("err.rst", 0, 0, 32'h0, 8'd0, 0, 0, 0);
      chk("err.cleared", err, 0);
`endif

      chk("sb.empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
